// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter that merges NUM_SRC AXI-Stream sources
// into one registered output stage, tagging each beat with its source index.
module axis_packet_arbiter #(
  parameter int NUM_SRC   = 2,
  parameter int DATA_BITS = 32,
  parameter int ID_BITS   = 3
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [NUM_SRC*DATA_BITS-1:0] axis_s_data_i,
  input  logic [NUM_SRC-1:0]           axis_s_valid_i,
  output logic [NUM_SRC-1:0]           axis_s_ready_o,
  input  logic [NUM_SRC-1:0]           axis_s_last_i,
  input  logic [NUM_SRC-1:0]           axis_s_user_i,
  output logic [DATA_BITS-1:0]         axis_m_data_o,
  output logic                         axis_m_valid_o,
  input  logic                         axis_m_ready_i,
  output logic                         axis_m_last_o,
  output logic                         axis_m_user_o,
  output logic [ID_BITS-1:0]           axis_m_id_o
);

  localparam int SW = ID_BITS + 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ID_BITS-1:0]     r_grant;
  logic [ID_BITS-1:0]     r_rr_last;
  logic [ID_BITS-1:0]     w_pick;
  logic                   w_any;
  logic [SW-1:0]          w_shamt;
  logic [SW-1:0]          w_off;
  logic [SW:0]            w_sum;
  logic [NUM_SRC-1:0]     w_rot;
  logic                   w_sel_valid;
  logic                   w_sel_last;
  logic                   w_sel_user;
  logic [DATA_BITS-1:0]   w_sel_data;
  logic [NUM_SRC-1:0]     w_s_ready;
  logic                   w_out_free;
  logic                   w_accept;
  logic                   r_m_valid;
  logic                   r_m_last;
  logic                   r_m_user;
  logic [DATA_BITS-1:0]   r_m_data;
  logic [ID_BITS-1:0]     r_m_id;

  assign w_out_free = !r_m_valid || axis_m_ready_i;
  assign w_accept   = (r_state == ST_LOCKED) && w_sel_valid && w_out_free;

  // Round-robin search: rotate valids so bit 0 is the source after rr_last,
  // take the lowest set bit, then map the offset back to a source index.
  always_comb begin
    w_shamt = {1'b0, r_rr_last} + SW'(1);
    w_rot   = NUM_SRC'({axis_s_valid_i, axis_s_valid_i} >> w_shamt);
    w_any   = |w_rot;
    w_off   = '0;
    for (int j = NUM_SRC - 1; j >= 0; j--) begin
      w_off = w_rot[j] ? SW'(j) : w_off;
    end
    w_sum  = {1'b0, w_shamt} + {1'b0, w_off};
    w_pick = ID_BITS'((w_sum >= (SW + 1)'(NUM_SRC)) ? (w_sum - (SW + 1)'(NUM_SRC)) : w_sum);
  end

  // Granted-source mux and ready fan-out; only the locked source ever sees ready.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_user  = 1'b0;
    w_sel_data  = '0;
    w_s_ready   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_sel_valid  = (r_grant == ID_BITS'(k)) ? axis_s_valid_i[k] : w_sel_valid;
      w_sel_last   = (r_grant == ID_BITS'(k)) ? axis_s_last_i[k]  : w_sel_last;
      w_sel_user   = (r_grant == ID_BITS'(k)) ? axis_s_user_i[k]  : w_sel_user;
      w_sel_data   = (r_grant == ID_BITS'(k)) ? axis_s_data_i[k*DATA_BITS +: DATA_BITS] : w_sel_data;
      w_s_ready[k] = (r_state == ST_LOCKED) && (r_grant == ID_BITS'(k)) && w_out_free;
    end
  end

  // Next-state logic: lock on any request, release once the last beat is taken.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_LOCKED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (w_accept && w_sel_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant is captured only while idle; rr_last advances when a packet completes.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_grant   <= '0;
      r_rr_last <= ID_BITS'(NUM_SRC - 1);
    end else begin
      if ((r_state == ST_IDLE) && w_any) begin
        r_grant <= w_pick;
      end
      if (w_accept && w_sel_last) begin
        r_rr_last <= r_grant;
      end
    end
  end

  // Output stage: load on accept, drop valid once consumed, otherwise hold.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_user  <= 1'b0;
      r_m_data  <= '0;
      r_m_id    <= '0;
    end else if (w_accept) begin
      r_m_valid <= 1'b1;
      r_m_last  <= w_sel_last;
      r_m_user  <= w_sel_user;
      r_m_data  <= w_sel_data;
      r_m_id    <= r_grant;
    end else if (r_m_valid && axis_m_ready_i) begin
      r_m_valid <= 1'b0;
    end
  end

  assign axis_s_ready_o = w_s_ready;
  assign axis_m_valid_o = r_m_valid;
  assign axis_m_last_o  = r_m_last;
  assign axis_m_user_o  = r_m_user;
  assign axis_m_data_o  = r_m_data;
  assign axis_m_id_o    = r_m_id;

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
- Shares one downstream AXI-Stream image pipeline stage (pipelined-register / processing datapath) between NUM_SRC upstream AXI-Stream sources.
- Arbitrates round-robin at packet granularity: a grant is held from the first accepted beat until the beat with last=1 is accepted.
- Registers the selected stream into a single output stage with full valid/ready handshake.
- Emits the winning source index alongside every output beat so downstream can demultiplex results.

Parameters:
- NUM_SRC, 2, number of requesting sources (2..8).
- DATA_BITS, 32, tdata width per source and on the output.
- ID_BITS, 3, width of axis_m_id_o; must satisfy 2**ID_BITS >= NUM_SRC.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rstn_i  input  1  asynchronous active-low reset.
- axis_s_data_i  input  NUM_SRC*DATA_BITS  source data; source k occupies bits [k*DATA_BITS +: DATA_BITS].
- axis_s_valid_i  input  NUM_SRC  per-source valid.
- axis_s_ready_o  output  NUM_SRC  per-source ready.
- axis_s_last_i  input  NUM_SRC  per-source end of packet (end of line).
- axis_s_user_i  input  NUM_SRC  per-source start of frame.
- axis_m_data_o  output  DATA_BITS  output data.
- axis_m_valid_o  output  1  output valid.
- axis_m_ready_i  input  1  downstream ready.
- axis_m_last_o  output  1  output last.
- axis_m_user_o  output  1  output user.
- axis_m_id_o  output  ID_BITS  index of the source that produced the current output beat.

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant=0, rr_last=NUM_SRC-1 (source 0 has first priority), axis_m_valid_o=0, axis_m_data_o/last/user/id=0, axis_s_ready_o=0.
- FSM states: IDLE and LOCKED.
- IDLE:
  - All axis_s_ready_o are 0.
  - If any valid is set, grant = first k with valid[k]=1, searching from rr_last+1 modulo NUM_SRC. Next state is LOCKED.
  - If no valid is set, stay in IDLE.
- LOCKED:
  - axis_s_ready_o[grant] = (!axis_m_valid_o || axis_m_ready_i). All other readies are 0.
  - Accept = valid[grant] && ready[grant].
  - On accept, the output register loads data/last/user of source grant, id=grant, and axis_m_valid_o=1.
  - On accept with last[grant]=1: rr_last=grant, next state is IDLE.
  - Grant never changes while LOCKED, even if valid[grant] drops mid-packet; the block waits for that source.
- Output register:
  - If axis_m_valid_o && axis_m_ready_i and there is no new accept, axis_m_valid_o goes to 0.
  - While axis_m_valid_o && !axis_m_ready_i, all axis_m_* outputs hold stable.
- Latency:
  - First beat of a packet is accepted 1 cycle after the arbitration cycle.
  - Each beat appears on the output 1 cycle after acceptance.
  - Sustained throughput within a packet is 1 beat/cycle when axis_m_ready_i=1.
  - There is exactly 1 idle arbitration cycle between packets.
- Non-granted sources see ready=0 and must hold their beat (AXI-Stream rule); the block never drops or reorders beats within a source.
- Single-beat packet (last on the first beat): LOCKED lasts one accept cycle, then returns to IDLE.
- A source requesting alone is re-granted after each packet. When several request, the grant rotates so that no source wins twice while another is waiting.
- Reset asserted mid-packet: everything clears immediately. The partial packet is abandoned; no recovery or flush is required.

Test Plan:
- Reset, then src0 sends a 4-beat packet (D=0x10..0x13, user on beat 0, last on beat 3) with m_ready=1 -> m_valid rises 2 cycles after s_valid; 4 consecutive beats 0x10..0x13; id=0; user on the first output beat, last on the fourth.
- src0 and src1 each continuously offer 3-beat packets -> output packet order is src0, src1, src0, src1; id matches each packet; one idle output cycle between packets; no interleaving inside a packet.
- Backpressure: m_ready toggles 1,0,0,1 during a src1 packet -> outputs stay stable while m_ready=0; s_ready[1]=0 during the stall; all beats are delivered exactly once in order.
- Granted src0 drops valid for 3 cycles mid-packet while src1 holds valid -> src1 is never granted until src0's last beat is accepted; then src1 is granted next.
- Single-beat packets (last=1) from src1 only, NUM_SRC=4 -> src1 is granted every 2 cycles; id=1; no other source is granted.
- Reset asserted during beat 2 of a 5-beat packet -> m_valid=0 and all s_ready=0 the same cycle; after release the next packet starts with source 0 priority.
